// File: rtl/ram_mp_if.sv
// Bus bundle for the multi-read-port RAM: one write port, NRD read ports, status.
interface ram_mp_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 3,
  parameter int unsigned NRD = 2
);
  logic                we;
  logic [AW-1:0]       waddr;
  logic [DW-1:0]       wdata;
  logic [DW/8-1:0]     wbe;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*DW-1:0]   rdata;
  logic [NRD-1:0]      rvalid;
  logic                busy;

  modport master (
    output we, waddr, wdata, wbe, re, raddr,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  we, waddr, wdata, wbe, re, raddr,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/ram_mp.sv
// Multi-read-port RAM with byte-masked write, selectable read latency,
// read-during-write policy and a post-reset clear engine.
module ram_mp #(
  parameter int unsigned   DW       = 8,
  parameter int unsigned   AW       = 3,
  parameter int unsigned   NRD      = 2,
  parameter int unsigned   RD_LAT   = 1,
  parameter int unsigned   RDW_MODE = 0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  ram_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned NB    = DW / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                busy_c;
  logic                wr_en_c;
  logic [DW-1:0]       mem_q [DEPTH];

  logic [AW-1:0]       ra_c;
  logic [DW-1:0]       old_c;
  logic [DW-1:0]       merged_c;
  logic [NRD*DW-1:0]   rd_data_c;
  logic [NRD-1:0]      rd_en_c;

  // State register and clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk the counter through every entry, then run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end
  end

  // Output decode: busy for the whole clear sweep
  always_comb begin
    busy_c = (state_q == CLEAR);
  end

  assign bus.busy = busy_c;
  assign wr_en_c  = bus.we & ~busy_c & ~rst;

  // Storage: clear engine has priority, user writes only while running
  always_ff @(posedge clk) begin
    if (!rst && busy_c) begin
      mem_q[cnt_q] <= INIT_VAL;
    end else if (wr_en_c) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (bus.wbe[b]) begin
          mem_q[bus.waddr][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // Per-port read source, optionally forwarding the byte-merged write data
  always_comb begin
    rd_data_c = '0;
    rd_en_c   = '0;
    ra_c      = '0;
    old_c     = '0;
    merged_c  = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ra_c     = bus.raddr[p*AW +: AW];
      old_c    = mem_q[ra_c];
      merged_c = old_c;
      for (int unsigned b = 0; b < NB; b++) begin
        if (bus.wbe[b]) begin
          merged_c[8*b +: 8] = bus.wdata[8*b +: 8];
        end
      end
      if ((RDW_MODE == 1) && bus.we && !busy_c && (ra_c == bus.waddr)) begin
        rd_data_c[p*DW +: DW] = merged_c;
      end else begin
        rd_data_c[p*DW +: DW] = old_c;
      end
      rd_en_c[p] = bus.re[p] & ~busy_c;
    end
  end

  if (RD_LAT == 0) begin : g_lat0
    assign bus.rdata  = rd_data_c;
    assign bus.rvalid = rd_en_c;
  end else begin : g_lat1p
    logic [NRD*DW-1:0] s1_data_q, s1_data_d;
    logic [NRD-1:0]    s1_valid_q;

    // Stage 1 data holds unless its port issued a read
    always_comb begin
      s1_data_d = s1_data_q;
      for (int unsigned p = 0; p < NRD; p++) begin
        if (rd_en_c[p]) begin
          s1_data_d[p*DW +: DW] = rd_data_c[p*DW +: DW];
        end
      end
    end

    // Stage 1 output register
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_data_q  <= '0;
        s1_valid_q <= '0;
      end else begin
        s1_data_q  <= s1_data_d;
        s1_valid_q <= rd_en_c;
      end
    end

    if (RD_LAT == 1) begin : g_lat1
      assign bus.rdata  = s1_data_q;
      assign bus.rvalid = s1_valid_q;
    end else begin : g_lat2
      logic [NRD*DW-1:0] s2_data_q;
      logic [NRD-1:0]    s2_valid_q;

      // Stage 2 copies stage 1 every cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data_q  <= '0;
          s2_valid_q <= '0;
        end else begin
          s2_data_q  <= s1_data_q;
          s2_valid_q <= s1_valid_q;
        end
      end

      assign bus.rdata  = s2_data_q;
      assign bus.rvalid = s2_valid_q;
    end
  end

endmodule
